// File: rtl/ysyx_22050598_mc_ctrl.sv
// Multi-cycle control FSM for the RV64I core: fetch/decode/execute/memory/writeback sequencing.
// Define YSYX_22050598_PERF_CNT_EN to build the cycle and retired-instruction counters.
module ysyx_22050598_mc_ctrl #(
  parameter int          CNT_W      = 64,
  parameter int unsigned IF_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  input  logic             ifu_resp_valid,
  output logic             ir_we,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [11:0]      funct12,
  input  logic             branch_taken,
  output logic             lsu_req_valid,
  output logic             lsu_req_we,
  input  logic             lsu_req_ready,
  input  logic             lsu_resp_valid,
  output logic             rf_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [1:0]       wb_sel,
  output logic             halt,
  output logic             halt_illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_IF_REQ   = 4'd1,
    S_IF_WAIT  = 4'd2,
    S_ID       = 4'd3,
    S_EX       = 4'd4,
    S_MEM_REQ  = 4'd5,
    S_MEM_WAIT = 4'd6,
    S_WB       = 4'd7,
    S_HALT     = 4'd8
  } state_e;

  // LUI/AUIPC/ALUI/ALUR sequence identically, so they share one class.
  typedef enum logic [2:0] {
    C_ALU, C_JAL, C_JALR, C_BRANCH, C_LOAD, C_STORE, C_EBREAK, C_ILLEGAL
  } class_e;

  state_e      state_q, state_d;
  class_e      class_q, class_d;
  logic        taken_q, taken_d;
  logic [31:0] to_q, to_d;
  logic        wait_expire;

  function automatic class_e decode_class(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [11:0] f12);
    case (op)
      7'b0110111, 7'b0010111, 7'b0010011,
      7'b0011011, 7'b0110011, 7'b0111011: decode_class = C_ALU;
      7'b1101111: decode_class = C_JAL;
      7'b1100111: decode_class = C_JALR;
      7'b1100011: decode_class = C_BRANCH;
      7'b0000011: decode_class = C_LOAD;
      7'b0100011: decode_class = C_STORE;
      7'b1110011: decode_class = (f3 == 3'd0 && f12 == 12'd1) ? C_EBREAK : C_ILLEGAL;
      default:    decode_class = C_ILLEGAL;
    endcase
  endfunction

  assign wait_expire = (IF_TIMEOUT != 32'd0) && ((to_q + 32'd1) == IF_TIMEOUT);

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    taken_d = taken_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_IF_REQ;
      S_IF_REQ:  if (ifu_req_ready) begin state_d = S_IF_WAIT; to_d = '0; end
      S_IF_WAIT: begin
        if (ifu_resp_valid) state_d = S_ID;
        else if (wait_expire) begin state_d = S_HALT; class_d = C_ILLEGAL; end
        else to_d = to_q + 32'd1;
      end
      S_ID: begin
        class_d = decode_class(opcode, funct3, funct12);
        state_d = (class_d == C_EBREAK || class_d == C_ILLEGAL) ? S_HALT : S_EX;
      end
      S_EX: begin
        taken_d = (class_q == C_BRANCH) && branch_taken;
        state_d = (class_q == C_LOAD || class_q == C_STORE) ? S_MEM_REQ : S_WB;
      end
      S_MEM_REQ: if (lsu_req_ready) begin state_d = S_MEM_WAIT; to_d = '0; end
      S_MEM_WAIT: begin
        if (lsu_resp_valid) state_d = S_WB;
        else if (wait_expire) begin state_d = S_HALT; class_d = C_ILLEGAL; end
        else to_d = to_q + 32'd1;
      end
      S_WB:   state_d = start ? S_IF_REQ : S_IDLE;
      S_HALT: state_d = S_HALT;
      default: begin state_d = S_HALT; class_d = C_ILLEGAL; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      class_q <= C_ALU;
      taken_q <= 1'b0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      taken_q <= taken_d;
      to_q    <= to_d;
    end
  end

  // ir_we is qualified by the response so IR captures the word while it is on the bus.
  assign ir_we = (state_q == S_IF_WAIT) && ifu_resp_valid;

  always_comb begin
    ifu_req_valid = (state_q == S_IF_REQ);
    lsu_req_valid = (state_q == S_MEM_REQ);
    lsu_req_we    = (state_q == S_MEM_REQ) && (class_q == C_STORE);
    pc_we         = (state_q == S_WB);
    rf_we         = 1'b0;
    pc_sel        = 2'b00;
    wb_sel        = 2'b00;
    if (state_q == S_WB) begin
      rf_we = (class_q != C_BRANCH) && (class_q != C_STORE);
      if (class_q == C_JAL || (class_q == C_BRANCH && taken_q)) pc_sel = 2'b01;
      else if (class_q == C_JALR)                                pc_sel = 2'b10;
      if (class_q == C_LOAD)                             wb_sel = 2'b01;
      else if (class_q == C_JAL || class_q == C_JALR)    wb_sel = 2'b10;
    end
    halt          = (state_q == S_HALT);
    halt_illegal  = (state_q == S_HALT) && (class_q != C_EBREAK);
  end

  assign state = state_q;

`ifdef YSYX_22050598_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, inst_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q  <= '0;
      inst_q <= '0;
    end else begin
      if (state_q != S_IDLE && state_q != S_HALT) cyc_q <= cyc_q + CNT_W'(1);
      if (state_q == S_WB) inst_q <= inst_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cyc_q;
  assign instret_cnt = inst_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule
